// File: rtl/obi_mem_responder.sv
// OBI-style single-port memory responder: configurable grant wait states,
// byte-enabled word storage and a fixed-latency response pipeline.
module obi_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          GNT_WAIT  = 0,
  parameter int          RSP_LAT   = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic        w_allow;
  logic        w_gnt;
  logic [31:0] w_offset;
  logic        w_in_range;
  logic [AW-1:0] w_idx;
  logic        w_wr;
  logic        w_rd;

  // With no wait states IDLE grants directly so requests can stream every cycle.
  assign w_allow = (r_state == S_READY) || ((GNT_WAIT == 0) && (r_state == S_IDLE));
  assign w_gnt   = req_i && w_allow && rst_ni;
  assign gnt_o   = w_gnt;

  assign w_offset   = addr_i - BASE_ADDR;
  assign w_in_range = (addr_i >= BASE_ADDR) && ({1'b0, w_offset} < SPAN);
  assign w_idx      = w_offset[AW+1:2];
  assign w_wr       = w_gnt && we_i && w_in_range;
  assign w_rd       = w_gnt && !we_i && w_in_range;

  // The counter reaches zero on the cycle READY is entered, so the grant
  // lands on request cycle GNT_WAIT+1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i && (GNT_WAIT != 0)) begin
            if (GNT_WAIT == 1) begin
              r_state    <= S_READY;
              r_wait_cnt <= '0;
            end else begin
              r_state    <= S_WAIT;
              r_wait_cnt <= 4'(GNT_WAIT - 1);
            end
          end
        end
        S_WAIT: begin
          if (!req_i) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
            if (r_wait_cnt == 4'd1) r_state <= S_READY;
          end
        end
        S_READY: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd_data;

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) r_mem[w_idx][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (w_rd) r_rd_data <= r_mem[w_idx];
  end

  // Stage 0 pairs the memory read register with its valid/err flags.
  logic r_v0;
  logic r_e0;
  logic r_z0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v0 <= 1'b0;
      r_e0 <= 1'b0;
      r_z0 <= 1'b0;
    end else begin
      r_v0 <= w_gnt;
      r_e0 <= w_gnt && !w_in_range;
      r_z0 <= w_gnt && (we_i || !w_in_range);
    end
  end

  logic [RSP_LAT-1:0]       w_pv;
  logic [RSP_LAT-1:0]       w_pe;
  logic [RSP_LAT-1:0][31:0] w_pd;

  assign w_pv[0] = r_v0;
  assign w_pe[0] = r_e0;
  assign w_pd[0] = (r_v0 && !r_z0) ? r_rd_data : 32'h0;

  for (genvar gi = 1; gi < RSP_LAT; gi++) begin : g_stage
    logic        r_valid;
    logic        r_err;
    logic [31:0] r_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_valid <= 1'b0;
        r_err   <= 1'b0;
        r_data  <= '0;
      end else begin
        r_valid <= w_pv[gi-1];
        r_err   <= w_pe[gi-1];
        r_data  <= w_pd[gi-1];
      end
    end

    assign w_pv[gi] = r_valid;
    assign w_pe[gi] = r_err;
    assign w_pd[gi] = r_data;
  end

  assign rvalid_o = w_pv[RSP_LAT-1];
  assign err_o    = w_pe[RSP_LAT-1];
  assign rdata_o  = w_pd[RSP_LAT-1];

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench for obi_mem_responder across three wait/latency configurations.
module tb_obi_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req    [3];
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];

  int          GW   [3] = '{0, 3, 0};
  int          RL   [3] = '{1, 1, 3};
  logic [31:0] BASE [3] = '{32'h0, 32'h0, 32'h100};

  obi_mem_responder #(.DEPTH(16), .BASE_ADDR(32'h0), .GNT_WAIT(0), .RSP_LAT(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));
  obi_mem_responder #(.DEPTH(16), .BASE_ADDR(32'h0), .GNT_WAIT(3), .RSP_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));
  obi_mem_responder #(.DEPTH(16), .BASE_ADDR(32'h100), .GNT_WAIT(0), .RSP_LAT(3)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          dut;
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [3][16];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE[d];
    return (a >= BASE[d]) && (off < 32'd64);
  endfunction

  // Drives one request, waits for its grant, and queues the expected response.
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] wd, input bit last);
    int   n;
    bit   granted;
    exp_t e;
    logic [31:0] off;
    req[d] = 1'b1; addr = a; we = w; be = b; wdata = wd;
    n = 0; granted = 1'b0;
    while (!granted && n < 40) begin
      @(negedge clk);
      n++;
      if (gnt[d]) granted = 1'b1;
    end
    if (!granted) begin
      check_val("gnt_timeout", 32'd0, 32'd1);
    end else begin
      check_val("gnt_lat", n, GW[d] + 1);
      off    = (a - BASE[d]) >> 2;
      e.dut  = d;
      e.cyc  = cyc + RL[d];
      e.err  = !in_rng(d, a);
      e.data = 32'h0;
      if (in_rng(d, a)) begin
        if (w) begin
          for (int i = 0; i < 4; i++)
            if (b[i]) mdl[d][off[3:0]][8*i +: 8] = wd[8*i +: 8];
        end else begin
          e.data = mdl[d][off[3:0]];
        end
      end
      sb.push_back(e);
      $display("xfer dut=%0d %s addr=%h be=%h wdata=%h exp_err=%0d exp_rdata=%h",
               d, w ? "WR" : "RD", a, b, wd, e.err, e.data);
    end
    @(posedge clk); #1;
    if (last) req[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (rvalid[d]) begin
          if (sb.size() == 0) begin
            check_val("unexpected_rvalid", 32'(d), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check_val("rsp_dut", 32'(d), 32'(e.dut));
            check_val("rsp_cyc", 32'(cyc), 32'(e.cyc));
            check_val("rsp_err", {31'h0, err[d]}, {31'h0, e.err});
            check_val("rsp_data", rdata[d], e.data);
          end
        end else begin
          check_val("idle_rdata", rdata[d], 32'h0);
          check_val("idle_err", {31'h0, err[d]}, 32'h0);
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("sb_drained", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) req[d] = 1'b0;
    addr = '0; we = 1'b0; be = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_val("rst_rvalid", {31'h0, rvalid[d]}, 32'h0);
      check_val("rst_rdata", rdata[d], 32'h0);
    end
    req[0] = 1'b1;
    #1 check_val("rst_gnt", {31'h0, gnt[0]}, 32'h0);
    req[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write then read-after-write, back to back.
    xfer(0, 1, 32'h0, 4'hF, 32'h0015_0513, 0);
    xfer(0, 0, 32'h0, 4'hF, 32'h0, 1);
    // Byte enables.
    xfer(0, 1, 32'h4, 4'hF, 32'hFFFF_FFFF, 0);
    xfer(0, 1, 32'h4, 4'b0001, 32'h0000_00AA, 0);
    xfer(0, 0, 32'h4, 4'hF, 32'h0, 0);
    xfer(0, 1, 32'h4, 4'b1010, 32'h1234_5678, 0);
    xfer(0, 0, 32'h7, 4'hF, 32'h0, 1);
    drain();
    check_val("be_model", mdl[0][1], 32'h12FF_56AA);
    // Range boundary: last word, first word past the end.
    xfer(0, 1, 32'h3C, 4'hF, 32'hCAFE_F00D, 0);
    xfer(0, 0, 32'h40, 4'hF, 32'h0, 0);
    xfer(0, 1, 32'h40, 4'hF, 32'hDEAD_BEEF, 0);
    xfer(0, 0, 32'h3C, 4'hF, 32'h0, 1);
    drain();
    // Fill dut0, then random traffic.
    for (int i = 0; i < 16; i++) xfer(0, 1, 32'(4*i), 4'hF, $urandom, i == 15);
    for (int i = 0; i < 24; i++)
      xfer(0, $urandom_range(0, 1), 32'($urandom_range(0, 17) * 4), 4'($urandom_range(0, 15)),
           $urandom, i == 23);
    drain();

    // Wait states: grant on the 4th request cycle.
    xfer(1, 1, 32'h8, 4'hF, 32'hA5A5_0001, 0);
    xfer(1, 0, 32'h8, 4'hF, 32'h0, 1);
    drain();
    req[1] = 1'b1; addr = 32'h8; we = 1'b0; be = 4'hF;
    repeat (2) begin
      @(negedge clk);
      check_val("gnt_wait", {31'h0, gnt[1]}, 32'h0);
    end
    @(posedge clk); #1;
    req[1] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check_val("gnt_dropped", {31'h0, gnt[1]}, 32'h0);
      check_val("rvalid_dropped", {31'h0, rvalid[1]}, 32'h0);
    end
    @(posedge clk); #1;
    xfer(1, 0, 32'h8, 4'hF, 32'h0, 1);
    drain();

    // Latency 3: back-to-back reads stream out in order.
    for (int i = 0; i < 4; i++) xfer(2, 1, 32'h100 + 32'(4*i), 4'hF, 32'h1111_0000 + 32'(i), i == 3);
    for (int i = 0; i < 4; i++) xfer(2, 0, 32'h100 + 32'(4*i), 4'hF, 32'h0, i == 3);
    xfer(2, 0, 32'hFC, 4'hF, 32'h0, 1);
    drain();

    // Reset with two reads outstanding, first already visible.
    xfer(2, 0, 32'h104, 4'hF, 32'h0, 0);
    xfer(2, 0, 32'h108, 4'hF, 32'h0, 1);
    @(posedge clk); #1;
    check_val("rvalid_pre_rst", {31'h0, rvalid[2]}, 32'h1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_val("rst_async_rvalid", {31'h0, rvalid[2]}, 32'h0);
    check_val("rst_async_rdata", rdata[2], 32'h0);
    check_val("rst_async_err", {31'h0, err[2]}, 32'h0);
    req[2] = 1'b1;
    #1 check_val("rst_gnt2", {31'h0, gnt[2]}, 32'h0);
    req[2] = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    xfer(2, 0, 32'h104, 4'hF, 32'h0, 0);
    xfer(2, 0, 32'h108, 4'hF, 32'h0, 1);
    drain();
    check_val("mem_kept", mdl[2][2], 32'h1111_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving the number of 32-bit words in storage (power of two).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
REQ-003 The block SHALL have parameter GNT_WAIT, default 0, giving the number of cycles req_i is held before gnt_o asserts (0..15).
REQ-004 The block SHALL have parameter RSP_LAT, default 1, giving the number of cycles from grant edge to rvalid_o (1..4).
REQ-005 The block SHALL have port clk_i, input, 1, the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1, an asynchronous active-low reset.
REQ-007 The block SHALL have port req_i, input, 1, a request from the core.
REQ-008 The block SHALL have port addr_i, input, 32, the byte address.
REQ-009 The block SHALL have port we_i, input, 1, write enable (1 = write, 0 = read).
REQ-010 The block SHALL have port be_i, input, 4, byte enables.
REQ-011 The block SHALL have port wdata_i, input, 32, write data.
REQ-012 The block SHALL have port gnt_o, output, 1, request accepted this cycle.
REQ-013 The block SHALL have port rvalid_o, output, 1, response valid.
REQ-014 The block SHALL have port rdata_o, output, 32, read data.
REQ-015 The block SHALL have port err_o, output, 1, out-of-range access flag; it is valid only while rvalid_o is 1.

Function
REQ-016 A transfer SHALL be accepted on a rising edge where req_i=1 and gnt_o=1; addr_i, we_i, be_i and wdata_i are sampled on that edge.
REQ-017 gnt_o SHALL be combinational from req_i and the FSM state, with no dependency on rvalid_o.
REQ-018 The grant FSM SHALL have three states: IDLE, WAIT and READY.
REQ-019 IDLE SHALL move to READY on req_i when GNT_WAIT=0, and to WAIT with wait_cnt=GNT_WAIT-1 otherwise.
REQ-020 WAIT SHALL decrement wait_cnt each cycle and move to READY when wait_cnt=0; it SHALL return to IDLE if req_i drops.
REQ-021 In READY, gnt_o SHALL equal req_i; after a grant, the FSM returns to IDLE, or restarts WAIT if GNT_WAIT>0.
REQ-022 With GNT_WAIT=0, gnt_o SHALL be asserted combinationally in the same cycle as req_i, allowing back-to-back grants every cycle.
REQ-023 In range SHALL mean BASE_ADDR <= addr_i < BASE_ADDR+4*DEPTH; the word index is (addr_i-BASE_ADDR)[log2(DEPTH)+1:2], and addr_i[1:0] SHALL be ignored.
REQ-024 A granted in-range write SHALL update, on the grant edge, exactly the bytes with be_i[n]=1 (bits 8n+7:8n).
REQ-025 A granted read SHALL capture the word on the grant edge; a read granted on the cycle after a write to the same word returns the new data.
REQ-026 Every granted transfer SHALL produce exactly one rvalid_o pulse of 1 cycle, exactly RSP_LAT cycles after its grant edge, in grant order.
REQ-027 Responses SHALL travel through an RSP_LAT-stage shift pipeline carrying {valid, err, rdata}; there is no backpressure, and up to RSP_LAT transfers MAY be outstanding.
REQ-028 For a write response, rdata_o SHALL be 0.
REQ-029 For an out-of-range access, err_o SHALL be 1, rdata_o SHALL be 0, and the write is dropped; storage is unchanged.
REQ-030 While rvalid_o=0, rdata_o and err_o SHALL be 0.

Reset
REQ-031 On assertion of rst_ni=0, and asynchronously to clk_i, the FSM SHALL go to IDLE, wait_cnt and all pipeline valid bits SHALL be cleared, and rvalid_o, err_o and rdata_o SHALL be 0.
REQ-032 gnt_o SHALL be 0 throughout reset.
REQ-033 Storage contents SHALL NOT be reset.
REQ-034 Responses in flight when reset asserts SHALL be discarded and never delivered.
REQ-035 The first grant after deassertion SHALL follow REQ-019 from IDLE.

Verification
REQ-036 Scenario (GNT_WAIT=0, RSP_LAT=1): write 32'h0015_0513 to 0x0 with be=4'hF, then read 0x0 -> grant in the request cycle; read rvalid_o 1 cycle after its grant; rdata_o=32'h0015_0513; err_o=0.
REQ-037 Scenario (byte enables): write 32'hFFFF_FFFF to 0x4 with be=4'hF, then write 32'h0000_00AA with be=4'b0001, then read 0x4 -> rdata_o=32'hFFFF_FFAA.
REQ-038 Scenario (GNT_WAIT=3): hold req_i -> gnt_o first high on the 4th cycle of the request; drop req_i in WAIT -> no grant is issued and no rvalid_o pulse occurs.
REQ-039 Scenario (RSP_LAT=3): 4 back-to-back reads of 0x0, 0x4, 0x8, 0xC -> 4 consecutive rvalid_o pulses starting 3 cycles after the first grant, with data in address order.
REQ-040 Scenario (range): read 4*DEPTH+BASE_ADDR -> err_o=1, rdata_o=0; write to the same address, then read the last valid word -> its data is unchanged.
REQ-041 Scenario (reset mid-operation): assert rst_ni=0 with 2 reads outstanding (RSP_LAT=3) -> rvalid_o=0 immediately; after release, no stale response appears and memory still holds prior data.
